// File: rtl/score_renderer.sv
// score_renderer
//   Converts a 14-bit binary score to four BCD digits (double-dabble, one
//   bit per cycle) once per requested frame, and renders those digits as a
//   64x16 pixel field at (X0, Y0) using an external 16x16 glyph ROM.
//
// Ports
//   clk         : pixel/system clock, rising edge
//   reset       : synchronous, active-high
//   frame_start : one-cycle pulse requesting a new conversion (ignored while busy)
//   score       : binary score, saturated to 9999 when captured
//   pix_x/pix_y : current pixel coordinate
//   rom_digit   : glyph index for the digit under the pixel (0 outside the field)
//   rom_line    : glyph row for the pixel (0 outside the field)
//   rom_data    : glyph row from the ROM, bit 15 is the leftmost pixel
//   pixel_on    : registered foreground flag, one cycle after pix_x/pix_y
//   busy        : high while a conversion is in progress
module score_renderer #(
  parameter int X0       = 16,
  parameter int Y0       = 16,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [13:0] score,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [3:0]  rom_digit,
  output logic [3:0]  rom_line,
  input  logic [15:0] rom_data,
  output logic        pixel_on,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] disp_q, disp_d;   // {d3, d2, d1, d0}
  logic        pixel_on_q, pixel_on_d;

  logic [15:0] bcd_adj;
  logic [29:0] shifted;

  // Conversion FSM
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin_q} << 1;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          bin_d   = (score > 14'd9999) ? 14'd9999 : score;
          bcd_d   = '0;
          cnt_d   = 4'd14;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = shifted[29:14];
        bin_d = shifted[13:0];
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        disp_d  = bcd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Rendering
  logic        in_region;
  logic [5:0]  dx;
  logic [3:0]  dy;
  logic [1:0]  slot;
  logic [3:0]  col;
  logic [3:0]  sel_digit;
  logic        blanked;

  always_comb begin
    in_region = ({1'b0, pix_x} >= 11'(X0)) && ({1'b0, pix_x} < 11'(X0) + 11'd64) &&
                ({1'b0, pix_y} >= 11'(Y0)) && ({1'b0, pix_y} < 11'(Y0) + 11'd16);
    dx   = 6'(pix_x - 10'(X0));
    dy   = 4'(pix_y - 10'(Y0));
    slot = dx[5:4];
    col  = dx[3:0];

    sel_digit = '0;
    blanked   = 1'b0;
    case (slot)
      2'd0: begin
        sel_digit = disp_q[15:12];
        blanked   = (disp_q[15:12] == 4'd0);
      end
      2'd1: begin
        sel_digit = disp_q[11:8];
        blanked   = (disp_q[15:8] == 8'd0);
      end
      2'd2: begin
        sel_digit = disp_q[7:4];
        blanked   = (disp_q[15:4] == 12'd0);
      end
      default: begin
        sel_digit = disp_q[3:0];
        blanked   = 1'b0;
      end
    endcase
    if (!BLANK_LZ) begin
      blanked = 1'b0;
    end

    rom_digit  = in_region ? sel_digit : 4'd0;
    rom_line   = in_region ? dy : 4'd0;
    pixel_on_d = in_region && !blanked && rom_data[4'd15 - col];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      pixel_on_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      pixel_on_q <= pixel_on_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign pixel_on = pixel_on_q;

endmodule

// File: tb/tb_score_renderer.sv
// Testbench for score_renderer: directed scenarios plus randomized traffic,
// checked against a behavioural model (decimal arithmetic on the displayed
// value, a countdown for the conversion latency).
module tb_score_renderer;

  localparam int X0 = 16;
  localparam int Y0 = 16;

  logic        clk = 1'b0;
  logic        rst, fs;
  logic [13:0] score;
  logic [9:0]  px, py;
  logic [15:0] rd;

  logic [3:0]  rom_digit, rom_line, rom_digit_nb, rom_line_nb;
  logic        pixel_on, busy, pixel_on_nb, busy_nb;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int m_cnt   = 0;
  int m_pend  = 0;
  int m_disp  = 0;
  bit chk_en  = 0;
  bit prev_busy = 0;
  int bsy_cycles = 0;
  int bsy_falls  = 0;

  always #5 clk = ~clk;

  score_renderer #(.X0(X0), .Y0(Y0), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .reset(rst), .frame_start(fs), .score(score),
    .pix_x(px), .pix_y(py), .rom_digit(rom_digit), .rom_line(rom_line),
    .rom_data(rd), .pixel_on(pixel_on), .busy(busy)
  );

  score_renderer #(.X0(X0), .Y0(Y0), .BLANK_LZ(1'b0)) u_dut_nb (
    .clk(clk), .reset(rst), .frame_start(fs), .score(score),
    .pix_x(px), .pix_y(py), .rom_digit(rom_digit_nb), .rom_line(rom_line_nb),
    .rom_data(rd), .pixel_on(pixel_on_nb), .busy(busy_nb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int p10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic bit inr(input int x, input int y);
    return (x >= X0) && (x < X0 + 64) && (y >= Y0) && (y < Y0 + 16);
  endfunction

  function automatic int exp_digit(input int x, input int y, input int disp);
    if (!inr(x, y)) return 0;
    return (disp / p10(3 - (x - X0) / 16)) % 10;
  endfunction

  function automatic int exp_line(input int x, input int y);
    return inr(x, y) ? (y - Y0) : 0;
  endfunction

  function automatic logic exp_pix(input int x, input int y, input int disp,
                                   input bit blank, input logic [15:0] r);
    int slot, c;
    if (!inr(x, y)) return 1'b0;
    slot = (x - X0) / 16;
    c    = (x - X0) % 16;
    // a leading slot is blank when the whole value is below its place value
    if (blank && slot != 3 && disp < p10(3 - slot)) return 1'b0;
    return r[15 - c];
  endfunction

  // One clock: check combinational outputs for the current inputs, advance
  // the model across the edge, then check the registered outputs.
  task automatic tick();
    logic ep, ep_nb;
    #1;
    if (chk_en) begin
      check("rom_digit", 32'(rom_digit), 32'(exp_digit(px, py, m_disp)));
      check("rom_line", 32'(rom_line), 32'(exp_line(px, py)));
      check("rom_digit_nb", 32'(rom_digit_nb), 32'(exp_digit(px, py, m_disp)));
    end
    ep    = rst ? 1'b0 : exp_pix(px, py, m_disp, 1'b1, rd);
    ep_nb = rst ? 1'b0 : exp_pix(px, py, m_disp, 1'b0, rd);
    @(posedge clk);
    if (rst) begin
      m_cnt  = 0;
      m_disp = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_disp = m_pend;
    end else if (fs) begin
      m_pend = (score > 9999) ? 9999 : int'(score);
      m_cnt  = 15;
    end
    #1;
    if (chk_en || rst) begin
      check("pixel_on", 32'(pixel_on), 32'(ep));
      check("pixel_on_nb", 32'(pixel_on_nb), 32'(ep_nb));
      check("busy", 32'(busy), 32'(m_cnt > 0));
      check("busy_nb", 32'(busy_nb), 32'(m_cnt > 0));
    end
    if (busy === 1'b1) bsy_cycles++;
    if (prev_busy && busy === 1'b0) bsy_falls++;
    prev_busy = (busy === 1'b1);
    if (rst) chk_en = 1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      px = 10'($urandom_range(X0 - 4, X0 + 68));
      py = 10'($urandom_range(Y0 - 2, Y0 + 18));
      rd = 16'($urandom);
      tick();
    end
  endtask

  task automatic start(input int s);
    score = 14'(s);
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  // visit every slot and a few rows with the given glyph data
  task automatic sweep(input logic [15:0] r);
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) begin
        px = 10'(X0 + s * 16 + $urandom_range(0, 15));
        py = 10'(Y0 + $urandom_range(0, 15));
        rd = r;
        tick();
      end
    end
  endtask

  initial begin
    rst = 1'b1; fs = 1'b0; score = '0; px = '0; py = '0; rd = '0;
    tick();
    tick();
    rst = 1'b0;
    check("busy_after_reset", 32'(busy), 32'd0);
    sweep(16'hFFFF);

    // 1234: busy length, committed digits, pixel at (X0+18, Y0+5)
    bsy_cycles = 0;
    start(1234);
    run(20);
    check("busy_len_1234", 32'(bsy_cycles), 32'd15);
    px = 10'(X0 + 18); py = 10'(Y0 + 5); rd = 16'($urandom);
    #1;
    check("digit_slot1_1234", 32'(rom_digit), 32'd2);
    check("line_1234", 32'(rom_line), 32'd5);
    tick();
    check("pix_rd13_1234", 32'(pixel_on), 32'(rd[13]));
    sweep(16'($urandom));

    // saturation
    start(12000);
    run(18);
    sweep(16'($urandom));

    // leading-zero blanking
    start(7);
    run(18);
    sweep(16'hFFFF);
    start(0);
    run(18);
    sweep(16'hFFFF);

    // second request while busy is ignored
    bsy_falls = 0;
    start(42);
    run(3);
    start(99);
    run(20);
    check("busy_falls_42", 32'(bsy_falls), 32'd1);
    sweep(16'($urandom));

    // reset mid-conversion aborts
    start(9999);
    run(18);
    start(5678);
    run(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(20);
    check("busy_after_abort", 32'(busy), 32'd0);
    sweep(16'hFFFF);

    // field boundaries
    rd = 16'hFFFF;
    px = 10'(X0 - 1);  py = 10'(Y0 + 5);  tick();
    px = 10'(X0 + 64); py = 10'(Y0 + 5);  tick();
    px = 10'(X0 + 20); py = 10'(Y0 + 16); tick();
    px = 10'(X0 + 20); py = 10'(Y0 - 1);  tick();
    px = 10'(X0);      py = 10'(Y0);      tick();
    px = 10'(X0 + 63); py = 10'(Y0 + 15); tick();
    tick();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      fs    = ($urandom_range(0, 7) == 0);
      score = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 120));
      px    = 10'($urandom_range(X0 - 4, X0 + 68));
      py    = 10'($urandom_range(Y0 - 2, Y0 + 18));
      rd    = 16'($urandom);
      tick();
    end
    rst = 1'b0; fs = 1'b0;
    run(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
